decode: RTL
===========

Name: decode

Overview:
- LC-3 decode stage, directly downstream of fetch.
- Captures the 16-bit instruction word returned from instruction memory at the address fetch drives on addr_out.
- Splits it into opcode, register, nzp and offset fields, and presents them as a registered bundle to execute through a valid/ready handshake.
- Supplies the opCode and offset values that fetch consumes for PC redirection.

Parameters:
- OFF_W, 11, width of the sign-extended offset output; must be >= 11; fetch uses bits [8:0].
- ILLEGAL_OP, 4'b1101, reserved opcode that traps the stage.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instr_in holds a valid memory word this cycle
- instr_in  in  16  instruction word from memory dout
- ready_out  out  1  stage can accept instr_valid this cycle
- exec_ready  in  1  execute accepts the current bundle
- decode_valid  out  1  output bundle valid
- opCode_out  out  4  ir[15:12]
- dr_out  out  3  ir[11:9] (DR, or SR for ST/STR/STI)
- br_nzp_out  out  3  ir[11:9]
- sr1_out  out  3  ir[8:6]
- sr2_out  out  3  ir[2:0]
- imm_mode_out  out  1  ir[5]
- imm5_out  out  5  ir[4:0]
- offset_out  out  OFF_W  extended offset (rules below)
- illegal_out  out  1  sticky: reserved opcode seen
- overrun_err  out  1  sticky: instr_valid while ready_out=0

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE.
  - All registered outputs, including decode_valid, illegal_out and overrun_err, go to 0.
  - ready_out is 0 while rst=1.
- States: IDLE, VALID, ILLEGAL.
- ready_out (combinational):
  - IDLE: 1.
  - VALID: equals exec_ready.
  - ILLEGAL: 0.
- Accept = instr_valid & ready_out. On accept:
  - All fields are registered from instr_in.
  - Latency is 1 cycle: decode_valid=1 in the cycle after accept.
  - If opcode==ILLEGAL_OP, go to ILLEGAL instead: decode_valid=0, illegal_out=1.
- IDLE transitions:
  - accept with legal opcode -> VALID.
  - accept with ILLEGAL_OP -> ILLEGAL.
  - otherwise stay in IDLE.
- VALID:
  - The output bundle holds stable while exec_ready=0.
  - exec_ready=1 and instr_valid=1 -> load the new word and stay in VALID (throughput 1 instruction/cycle).
  - exec_ready=1 and instr_valid=0 -> IDLE, decode_valid=0. Fields keep their last values and are don't-care.
- ILLEGAL: terminal until rst.
- Overrun: instr_valid=1 while ready_out=0 (stall or ILLEGAL):
  - The word is discarded.
  - overrun_err sets and stays set until rst.
  - The held bundle is unaffected.
- offset_out selection, by ir[15:12]:
  - BR 0000, LD 0010, ST 0011, LDI 1010, STI 1011, LEA 1110: sext(ir[8:0]).
  - LDR 0110, STR 0111: sext(ir[5:0]).
  - JSR 0100 with ir[11]=1: sext(ir[10:0]).
  - TRAP 1111: zext(ir[7:0]).
  - All other opcodes: 0.
- BR with nzp=000 is a legal NOP and is passed through normally.
- RTI 1000 is passed through with no special handling.

Decomposition:
- Shared package lc3_pkg holds:
  - the 4-bit opcode constants (OP_BR … OP_TRAP, OP_RES=1101);
  - the state encoding (IDLE=0, VALID=1, ILLEGAL=2);
  - the instruction-field bit positions.
- One natural sub-module, offset_ext: combinational, instr[15:0] -> offset[OFF_W-1:0], so fetch/execute benches can reuse it.

Test Plan:
- Reset: hold rst=1 for 5 cycles -> all outputs 0, ready_out=0. Release rst -> ready_out=1 in the same cycle, decode_valid stays 0.
- LDR: instr_in=16'h6A7E, one-cycle instr_valid, exec_ready=1 -> next cycle decode_valid=1, opCode_out=4'b0110, dr_out=5, sr1_out=1, offset_out=11'h7FE. The cycle after, decode_valid=0.
- BR and TRAP:
  - 16'h0A05 -> br_nzp_out=3'b101, offset_out=11'h005.
  - 16'hF025 -> offset_out=11'h025.
  - 16'h4FFF (JSR) -> offset_out=11'h7FF.
- Back-to-back and stall:
  - 16'h1283 then 16'h5262 on consecutive cycles with exec_ready=1 -> decode_valid stays 1 and fields update every cycle.
  - Then exec_ready=0 for 3 cycles -> bundle held, ready_out=0.
  - instr_valid during the stall -> overrun_err=1, bundle unchanged.
- Illegal: instr_in=16'hD000 accepted -> illegal_out=1, decode_valid=0, ready_out=0. Further instr_valid sets overrun_err and the stage stays in ILLEGAL until rst.
- Reset mid-VALID: assert rst between clock edges while decode_valid=1 -> decode_valid, illegal_out, overrun_err and all fields go to 0 before the next edge.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 opcode, FSM-state and instruction-field definitions for the decode/fetch/execute slice.
// Pure declarations; no logic, no latency, no flow control.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_VALID   = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;

  localparam int OPC_LSB      = 12;
  localparam int DR_LSB       = 9;
  localparam int SR1_LSB      = 6;
  localparam int SR2_LSB      = 0;
  localparam int IMM_BIT      = 5;
  localparam int JSR_MODE_BIT = 11;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dr;
    logic [2:0] nzp;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       imm_mode;
    logic [4:0] imm5;
  } fields_t;

  function automatic fields_t split_fields(input logic [15:0] ir);
    fields_t f;
    f.opcode   = ir[OPC_LSB +: 4];
    f.dr       = ir[DR_LSB +: 3];
    f.nzp      = ir[DR_LSB +: 3];
    f.sr1      = ir[SR1_LSB +: 3];
    f.sr2      = ir[SR2_LSB +: 3];
    f.imm_mode = ir[IMM_BIT];
    f.imm5     = ir[4:0];
    return f;
  endfunction

endpackage

// File: rtl/offset_ext.sv
// Opcode-directed offset extraction and sign/zero extension of an LC-3 instruction word.
// Purely combinational (0 cycles); no flow control.
module offset_ext
  import lc3_pkg::*;
#(
  parameter int OFF_W = 11
) (
  input  logic [15:0]      instr,
  output logic [OFF_W-1:0] offset
);

  always_comb begin
    offset = '0;
    case (instr[OPC_LSB +: 4])
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: offset = OFF_W'($signed(instr[8:0]));
      OP_LDR, OP_STR:                              offset = OFF_W'($signed(instr[5:0]));
      // JSRR (mode bit clear) takes its target from a register, so no offset
      OP_JSR:  if (instr[JSR_MODE_BIT]) offset = OFF_W'($signed(instr[10:0]));
      OP_TRAP: offset = OFF_W'(instr[7:0]);
      default: offset = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: registers instruction fields into a bundle for execute, 1-cycle latency.
// Valid/ready: holds the bundle while exec_ready=0; words offered while not ready are dropped and flagged.
module decode
  import lc3_pkg::*;
#(
  parameter int         OFF_W      = 11,
  parameter logic [3:0] ILLEGAL_OP = OP_RES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr_in,
  output logic             ready_out,
  input  logic             exec_ready,
  output logic             decode_valid,
  output logic [3:0]       opCode_out,
  output logic [2:0]       dr_out,
  output logic [2:0]       br_nzp_out,
  output logic [2:0]       sr1_out,
  output logic [2:0]       sr2_out,
  output logic             imm_mode_out,
  output logic [4:0]       imm5_out,
  output logic [OFF_W-1:0] offset_out,
  output logic             illegal_out,
  output logic             overrun_err
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  fields_t          fld;
  logic [OFF_W-1:0] off_reg;
  logic [OFF_W-1:0] off_nxt;
  logic             overrun;
  logic             accept;
  logic             is_illegal;

  offset_ext #(.OFF_W(OFF_W)) u_offset_ext (
    .instr  (instr_in),
    .offset (off_nxt)
  );

  // ready is gated by rst because the async reset already parks state in IDLE
  always_comb begin
    ready_out = 1'b0;
    case (state)
      ST_IDLE:  ready_out = 1'b1;
      ST_VALID: ready_out = exec_ready;
      default:  ready_out = 1'b0;
    endcase
    if (rst) ready_out = 1'b0;
  end

  assign accept     = instr_valid & ready_out;
  assign is_illegal = (instr_in[OPC_LSB +: 4] == ILLEGAL_OP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = is_illegal ? ST_ILLEGAL : ST_VALID;
      end
      ST_VALID: begin
        if (accept)          state_nxt = is_illegal ? ST_ILLEGAL : ST_VALID;
        else if (exec_ready) state_nxt = ST_IDLE;
      end
      ST_ILLEGAL: state_nxt = ST_ILLEGAL;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      fld     <= '0;
      off_reg <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        fld     <= split_fields(instr_in);
        off_reg <= off_nxt;
      end
      if (instr_valid && !ready_out) overrun <= 1'b1;
    end
  end

  assign decode_valid = (state == ST_VALID);
  assign illegal_out  = (state == ST_ILLEGAL);
  assign overrun_err  = overrun;
  assign opCode_out   = fld.opcode;
  assign dr_out       = fld.dr;
  assign br_nzp_out   = fld.nzp;
  assign sr1_out      = fld.sr1;
  assign sr2_out      = fld.sr2;
  assign imm_mode_out = fld.imm_mode;
  assign imm5_out     = fld.imm5;
  assign offset_out   = off_reg;

endmodule
